uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter OVERSAMPLE, default 16, meaning clken ticks per bit period (power of two, 8..32).
REQ-002 SHALL have parameter DATA_BITS, default 8, meaning payload bits per frame.
REQ-003 SHALL have port clk_50m  input  1  sole clock; all flops rising-edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port clken  input  1  oversample enable, one-cycle pulse at OVERSAMPLE x baud.
REQ-006 SHALL have port rx  input  1  asynchronous serial line, idle high.
REQ-007 SHALL have port rdy_clr  input  1  consumer acknowledge, clears rdy.
REQ-008 SHALL have port data  output  DATA_BITS  last good received byte, LSB first on the line.
REQ-009 SHALL have port rdy  output  1  data holds an unconsumed byte.
REQ-010 SHALL have port frame_err  output  1  last frame had a low stop bit.
REQ-011 SHALL have port overrun  output  1  a good byte arrived while rdy was already set.
REQ-012 SHALL have port rx_busy  output  1  high whenever state is not IDLE.

Function
REQ-013 SHALL pass rx through a 2-flop synchronizer; all decisions use the synchronized value rx_s.
REQ-014 SHALL implement states IDLE, START, DATA, STOP; state, sample counter and bit counter advance only on cycles with clken=1.
REQ-015 IDLE: on clken with rx_s=0 -> START, sample counter=0.
REQ-016 START: when sample counter reaches OVERSAMPLE/2-1 and rx_s=0 -> DATA, counter=0; if rx_s=1 at that tick -> IDLE (glitch reject, no flags change).
REQ-017 DATA: at counter=OVERSAMPLE-1 sample rx_s into shift register (LSB first), counter wraps to 0; after DATA_BITS samples -> STOP.
REQ-018 STOP: at counter=OVERSAMPLE-1, rx_s=1 -> data<=shift register, rdy<=1, frame_err<=0; rx_s=0 -> frame_err<=1, data and rdy unchanged; either way -> IDLE.
REQ-019 Good byte completing while rdy=1 and rdy_clr=0 SHALL set overrun=1 and overwrite data.
REQ-020 rdy_clr=1 SHALL clear rdy and overrun next cycle, unless a good byte completes in the same cycle, in which case rdy=1 and overrun=0.
REQ-021 frame_err SHALL be sticky until the next completed frame (good or bad); rdy_clr does not clear it.
REQ-022 Latency: rdy rises on the clk_50m edge at the STOP mid-bit tick, ~(DATA_BITS+1.5) bit periods after the start-bit falling edge plus 2 synchronizer cycles.
REQ-023 rx held low continuously SHALL yield frame_err=1 then immediately re-enter START on the next clken (break is not special-cased).
REQ-024 clken stuck low SHALL freeze the receiver in its current state with no output changes.

Reset
REQ-025 rst_n=0 at a clock edge SHALL force state=IDLE, counters=0, shift register=0, synchronizer flops=1, data=0, rdy=0, frame_err=0, overrun=0, rx_busy=0, regardless of clken.
REQ-026 Reset mid-frame SHALL discard the partial byte; the next start bit is detected only after rx_s has returned high and falls again.

Structure
REQ-027 State encodings (IDLE=2'b00, START=2'b01, DATA=2'b10, STOP=2'b11) and default OVERSAMPLE SHALL live in shared package uart_pkg, also used by the transmitter.
REQ-028 The synchronizer SHALL be a separate sub-module uart_rx_sync (2 flops, reset value 1); all other logic stays in uart_rx.

Verification
REQ-029 Frame 0xA5 at 16x clken, rdy_clr low -> data=0xA5, rdy=1, frame_err=0, overrun=0, rx_busy low after STOP.
REQ-030 rx low for 4 clken ticks then high -> state back to IDLE, rdy=0, data unchanged, no flags.
REQ-031 Frame 0x3C with stop bit driven low -> frame_err=1, rdy=0, data keeps previous value; following good 0x0F -> data=0x0F, frame_err=0.
REQ-032 Back-to-back frames 0x11 then 0x22, no rdy_clr -> data=0x22, rdy=1, overrun=1; pulse rdy_clr -> rdy=0, overrun=0.
REQ-033 rdy_clr asserted in the exact cycle 0x55 completes with rdy=1 -> rdy=1, overrun=0, data=0x55.
REQ-034 rst_n low for one cycle during DATA bit 4 of 0xFF -> all outputs 0 next cycle; subsequent clean 0x81 -> data=0x81, rdy=1.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg -- definitions shared by the UART receiver and transmitter.
//   uart_state_t    : frame state encoding (IDLE/START/DATA/STOP)
//   UART_OVERSAMPLE : default number of clken ticks per bit period
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      START = 2'b01,
      DATA  = 2'b10,
      STOP  = 2'b11
   } uart_state_t;

   localparam int UART_OVERSAMPLE = 16;

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync -- two-flop synchronizer for the asynchronous rx line.
//   clk_50m : clock
//   rst_n   : synchronous active-low reset; both flops reset to 1 (line idle)
//   d       : asynchronous input
//   q       : synchronized output
module uart_rx_sync (
   input  logic clk_50m,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk_50m) begin
      if (!rst_n) begin
         meta <= 1'b1;
         q    <= 1'b1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// uart_rx -- oversampling UART receiver (8N1 by default, LSB first).
//   clk_50m   : clock; all flops rising-edge
//   rst_n     : synchronous active-low reset
//   clken     : oversample enable pulse, OVERSAMPLE per bit period
//   rx        : asynchronous serial line, idle high
//   rdy_clr   : consumer acknowledge, clears rdy and overrun
//   data      : last good received byte
//   rdy       : data holds an unconsumed byte
//   frame_err : last completed frame had a low stop bit (sticky until next frame)
//   overrun   : a good byte arrived while rdy was still set
//   rx_busy   : receiver is inside a frame (state != IDLE)
module uart_rx
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE = UART_OVERSAMPLE,
   parameter int DATA_BITS  = 8
) (
   input  logic                 clk_50m,
   input  logic                 rst_n,
   input  logic                 clken,
   input  logic                 rx,
   input  logic                 rdy_clr,
   output logic [DATA_BITS-1:0] data,
   output logic                 rdy,
   output logic                 frame_err,
   output logic                 overrun,
   output logic                 rx_busy
);

   localparam int CW = $clog2(OVERSAMPLE);
   localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   localparam logic [CW-1:0] CNT_HALF = CW'(OVERSAMPLE/2 - 1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

   logic                 rx_s;
   uart_state_t          state, state_nxt;
   logic [CW-1:0]        cnt, cnt_nxt;
   logic [BW-1:0]        bit_cnt, bit_nxt;
   logic [DATA_BITS-1:0] shreg;
   logic                 shift_en;
   logic                 stop_good;
   logic                 stop_bad;

   uart_rx_sync u_sync (
      .clk_50m (clk_50m),
      .rst_n   (rst_n),
      .d       (rx),
      .q       (rx_s)
   );

   // Next-state logic. Nothing moves unless clken is high, so a stuck-low
   // clken freezes the frame exactly where it is.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      bit_nxt   = bit_cnt;
      shift_en  = 1'b0;
      stop_good = 1'b0;
      stop_bad  = 1'b0;
      if (clken) begin
         case (state)
            IDLE: begin
               if (!rx_s) begin
                  state_nxt = START;
                  cnt_nxt   = '0;
               end
            end
            START: begin
               // Re-check the line at mid start bit; a high here was a glitch.
               if (cnt == CNT_HALF) begin
                  cnt_nxt   = '0;
                  bit_nxt   = '0;
                  state_nxt = rx_s ? IDLE : DATA;
               end else begin
                  cnt_nxt = cnt + CW'(1);
               end
            end
            DATA: begin
               // Counter was zeroed at mid start bit, so wrap points are mid-bit.
               if (cnt == CNT_MAX) begin
                  cnt_nxt  = '0;
                  shift_en = 1'b1;
                  if (bit_cnt == BIT_LAST) begin
                     bit_nxt   = '0;
                     state_nxt = STOP;
                  end else begin
                     bit_nxt = bit_cnt + BW'(1);
                  end
               end else begin
                  cnt_nxt = cnt + CW'(1);
               end
            end
            STOP: begin
               if (cnt == CNT_MAX) begin
                  cnt_nxt   = '0;
                  state_nxt = IDLE;
                  stop_good = rx_s;
                  stop_bad  = !rx_s;
               end else begin
                  cnt_nxt = cnt + CW'(1);
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_50m) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         bit_cnt   <= '0;
         shreg     <= '0;
         data      <= '0;
         rdy       <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         bit_cnt <= bit_nxt;
         if (shift_en)
            shreg <= {rx_s, shreg[DATA_BITS-1:1]};
         if (stop_good) begin
            // A same-cycle acknowledge consumes the old byte, so no overrun.
            data      <= shreg;
            rdy       <= 1'b1;
            frame_err <= 1'b0;
            overrun   <= rdy & ~rdy_clr;
         end else begin
            if (stop_bad)
               frame_err <= 1'b1;
            if (rdy_clr) begin
               rdy     <= 1'b0;
               overrun <= 1'b0;
            end
         end
      end
   end

   assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx -- directed self-checking bench for uart_rx at 16x oversample,
// clken every 4th clock (one bit period = 64 clocks).
module tb_uart_rx;

   localparam int BIT_CLKS = 64;

   logic       clk_50m = 1'b0;
   logic       rst_n   = 1'b0;
   logic       clken;
   logic       clken_on = 1'b1;
   logic       rx       = 1'b1;
   logic       rdy_clr  = 1'b0;
   logic [7:0] data;
   logic       rdy;
   logic       frame_err;
   logic       overrun;
   logic       rx_busy;

   logic [1:0] div = 2'd0;
   int         cyc = 0;
   int         rise_cyc = 0;
   logic       rdy_prev = 1'b0;
   int         t0 = 0;
   int         lat = 0;
   int         n_chk = 0;
   int         n_fail = 0;

   uart_rx #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
      .clk_50m   (clk_50m),
      .rst_n     (rst_n),
      .clken     (clken),
      .rx        (rx),
      .rdy_clr   (rdy_clr),
      .data      (data),
      .rdy       (rdy),
      .frame_err (frame_err),
      .overrun   (overrun),
      .rx_busy   (rx_busy)
   );

   initial forever #10 clk_50m = ~clk_50m;

   // clken divider advances on the falling edge so it is stable at rising edges
   initial forever begin
      @(negedge clk_50m);
      div = div + 2'd1;
   end
   assign clken = clken_on & (div == 2'd0);

   // cycle index and rdy rising-edge timestamp, sampled just after each edge
   initial forever begin
      @(posedge clk_50m);
      #1;
      cyc = cyc + 1;
      if (rdy && !rdy_prev)
         rise_cyc = cyc;
      rdy_prev = rdy;
   end

   initial begin
      #4000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk_50m);
   endtask

   // wait for a clken edge, then drive on the following falling edge
   task automatic align();
      do @(posedge clk_50m); while (div != 2'd0);
      @(negedge clk_50m);
      t0 = cyc;
   endtask

   // one frame; clr_at > 0 pulses rdy_clr so it is sampled clr_at edges after t0
   task automatic send_frame(input logic [7:0] b, input logic stop, input int clr_at);
      align();
      fork
         begin
            rx = 1'b0;
            idle(BIT_CLKS);
            for (int i = 0; i < 8; i++) begin
               rx = b[i];
               idle(BIT_CLKS);
            end
            rx = stop;
            idle(BIT_CLKS);
            rx = 1'b1;
         end
         if (clr_at > 0) begin
            idle(clr_at - 1);
            rdy_clr = 1'b1;
            @(negedge clk_50m);
            rdy_clr = 1'b0;
         end
      join
   endtask

   task automatic pulse_clr();
      rdy_clr = 1'b1;
      @(negedge clk_50m);
      rdy_clr = 1'b0;
      @(negedge clk_50m);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_data"}, 32'(data), 32'h0);
      chk({tag, "_rdy"},  32'(rdy), 32'h0);
      chk({tag, "_ferr"}, 32'(frame_err), 32'h0);
      chk({tag, "_ovr"},  32'(overrun), 32'h0);
      chk({tag, "_busy"}, 32'(rx_busy), 32'h0);
   endtask

   initial begin
      idle(5);
      chk_zero("reset");
      rst_n = 1'b1;
      idle(20);

      // good frame 0xA5; expected latency 612 edges (4 to first clken + 608)
      send_frame(8'hA5, 1'b1, 0);
      lat = rise_cyc - t0;
      idle(BIT_CLKS);
      chk("a5_data", 32'(data), 32'hA5);
      chk("a5_rdy",  32'(rdy), 32'h1);
      chk("a5_ferr", 32'(frame_err), 32'h0);
      chk("a5_ovr",  32'(overrun), 32'h0);
      chk("a5_busy", 32'(rx_busy), 32'h0);
      chk("a5_latency", 32'(lat), 32'd612);
      pulse_clr();
      chk("clr_rdy", 32'(rdy), 32'h0);

      // start-bit glitch: 4 clken ticks low
      align();
      rx = 1'b0;
      idle(10);
      chk("glitch_busy_in", 32'(rx_busy), 32'h1);
      idle(6);
      rx = 1'b1;
      idle(2 * BIT_CLKS);
      chk("glitch_busy", 32'(rx_busy), 32'h0);
      chk("glitch_rdy",  32'(rdy), 32'h0);
      chk("glitch_data", 32'(data), 32'hA5);
      chk("glitch_ferr", 32'(frame_err), 32'h0);
      chk("glitch_ovr",  32'(overrun), 32'h0);

      // framing error, then recovery
      send_frame(8'h3C, 1'b0, 0);
      idle(2 * BIT_CLKS);
      chk("ferr_flag", 32'(frame_err), 32'h1);
      chk("ferr_rdy",  32'(rdy), 32'h0);
      chk("ferr_data", 32'(data), 32'hA5);
      pulse_clr();
      chk("ferr_sticky", 32'(frame_err), 32'h1);
      send_frame(8'h0F, 1'b1, 0);
      idle(BIT_CLKS);
      chk("0f_data", 32'(data), 32'h0F);
      chk("0f_ferr", 32'(frame_err), 32'h0);
      chk("0f_rdy",  32'(rdy), 32'h1);
      pulse_clr();

      // back-to-back without acknowledge -> overrun
      send_frame(8'h11, 1'b1, 0);
      chk("11_rdy", 32'(rdy), 32'h1);
      chk("11_ovr", 32'(overrun), 32'h0);
      send_frame(8'h22, 1'b1, 0);
      idle(BIT_CLKS);
      chk("22_data", 32'(data), 32'h22);
      chk("22_rdy",  32'(rdy), 32'h1);
      chk("22_ovr",  32'(overrun), 32'h1);
      pulse_clr();
      chk("ovr_clr_rdy", 32'(rdy), 32'h0);
      chk("ovr_clr_ovr", 32'(overrun), 32'h0);

      // acknowledge in the very cycle the next byte completes
      send_frame(8'h44, 1'b1, 0);
      idle(BIT_CLKS);
      chk("44_rdy", 32'(rdy), 32'h1);
      send_frame(8'h55, 1'b1, 612);
      idle(BIT_CLKS);
      chk("55_rdy",  32'(rdy), 32'h1);
      chk("55_ovr",  32'(overrun), 32'h0);
      chk("55_data", 32'(data), 32'h55);

      // one-cycle reset during data bit 4 of 0xFF
      fork
         send_frame(8'hFF, 1'b1, 0);
         begin
            idle(355);
            rst_n = 1'b0;
            @(negedge clk_50m);
            chk_zero("midrst");
            rst_n = 1'b1;
         end
      join
      idle(2 * BIT_CLKS);
      chk("midrst_rdy_after", 32'(rdy), 32'h0);
      send_frame(8'h81, 1'b1, 0);
      idle(BIT_CLKS);
      chk("81_data", 32'(data), 32'h81);
      chk("81_rdy",  32'(rdy), 32'h1);
      chk("81_ferr", 32'(frame_err), 32'h0);

      // clken stuck low mid-frame freezes everything; reset still works
      align();
      rx = 1'b0;
      idle(100);
      clken_on = 1'b0;
      rx = 1'b1;
      idle(100);
      rx = 1'b0;
      idle(100);
      rx = 1'b1;
      idle(100);
      chk("frz_busy", 32'(rx_busy), 32'h1);
      chk("frz_rdy",  32'(rdy), 32'h1);
      chk("frz_data", 32'(data), 32'h81);
      chk("frz_ferr", 32'(frame_err), 32'h0);
      rst_n = 1'b0;
      @(negedge clk_50m);
      chk_zero("frzrst");
      rst_n = 1'b1;
      clken_on = 1'b1;
      idle(20);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
